pcpi_gf_initiator: RTL
======================

PCPI_GF_INITIATOR -- requirements
Module: pcpi_gf_initiator

Interface
REQ-001 SHALL have parameters: DATA_WIDTH, default 32, width of the operand and result buses; TIMEOUT_CYCLES, default 16, number of no-wait cycles before a command is declared unclaimed.
REQ-002 SHALL have ports:
- clk  in  1  clock, rising-edge.
- resetn  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when high with cmd_valid.
- cmd_insn  in  32  RISC-V R-type instruction word.
- cmd_rs1  in  DATA_WIDTH  operand 1.
- cmd_rs2  in  DATA_WIDTH  operand 2.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  DATA_WIDTH  result.
- rsp_wr  out  1  result is valid for register writeback.
- rsp_err  out  1  command unclaimed, timed out or rejected.
- pcpi_valid  out  1  PCPI request.
- pcpi_insn  out  32  PCPI instruction.
- pcpi_rs1  out  DATA_WIDTH  PCPI operand 1.
- pcpi_rs2  out  DATA_WIDTH  PCPI operand 2.
- pcpi_wr  in  1  responder writes rd.
- pcpi_rd  in  DATA_WIDTH  responder result.
- pcpi_wait  in  1  responder claims the instruction, still busy.
- pcpi_ready  in  1  responder done.

Function
REQ-003 SHALL implement FSM states IDLE, BUSY, RESP.
REQ-004 IDLE: cmd_ready=1; on cmd_valid, SHALL latch insn/rs1/rs2 and go to BUSY; pcpi_valid SHALL rise on the next cycle.
REQ-005 BUSY: pcpi_valid=1, pcpi_insn/rs1/rs2 SHALL be held constant; cmd_ready=0.
REQ-006 On entering BUSY, a timeout counter SHALL load TIMEOUT_CYCLES.
- It SHALL decrement each BUSY cycle with pcpi_wait=0 and pcpi_ready=0.
- It SHALL reload to TIMEOUT_CYCLES on any cycle with pcpi_wait=1.
REQ-007 pcpi_ready=1 in BUSY SHALL capture rsp_data=pcpi_wr?pcpi_rd:0, rsp_wr=pcpi_wr, rsp_err=0, and go to RESP; pcpi_valid SHALL be low from the next cycle.
REQ-008 Counter reaching 0 in BUSY without pcpi_ready SHALL go to RESP with rsp_err=1, rsp_wr=0, rsp_data=0, and drop pcpi_valid.
REQ-009 pcpi_ready and timeout in the same cycle: pcpi_ready SHALL win.
REQ-010 RESP: rsp_valid=1 with data held stable until rsp_ready=1, then IDLE; rsp_ready=0 SHALL stall indefinitely.
REQ-011 Latency: cmd handshake at cycle N, pcpi_ready sampled at M, rsp_valid at M+1; minimum handshake-to-rsp_valid is 2 cycles.
REQ-012 pcpi_ready/pcpi_wait outside BUSY SHALL be ignored.
REQ-013 No command SHALL be accepted before the current response handshakes; there is no combinational path from cmd_valid to cmd_ready.

Reset
REQ-014 While resetn=0: state=IDLE; outputs pcpi_valid, rsp_valid, rsp_wr, rsp_err=0; rsp_data, pcpi_insn/rs1/rs2=0; cmd_ready=0.
REQ-015 Reset mid-transaction SHALL discard the in-flight command with no response.
REQ-016 cmd_ready SHALL assert on the first clock edge after deassertion.

Configuration
REQ-017 Macro PCPI_GF_INITIATOR_INSN_FILTER_EN gates command filtering.
- Defined: a command whose opcode!=0110011 or funct7 not in {0000001, 0000100} SHALL go IDLE->RESP directly with rsp_err=1, without asserting pcpi_valid.
- Undefined: all commands SHALL be forwarded.

Structure
REQ-018 A shared package SHALL hold: state enum; OPCODE_R=7'b0110011, FUNCT7_R=7'b0000001, FUNCT7_G=7'b0000100; funct3 codes CLMUL=0, CLMULH=2, GLWIDTH=4, GFRED=1.
REQ-019 Sub-module pcpi_timeout_ctr (load/decrement/zero flag) SHALL be the only child.

Verification
REQ-020 CLMUL insn 0x08208233, rs1=0xE, rs2=0xF, responder waits 3 cycles -> rsp_data=0x5A, rsp_wr=1, rsp_err=0.
REQ-021 MUL insn 0x02208233, rs1=0x743, rs2=0x7FE, responder ready 1 cycle later with pcpi_wr=1 -> rsp_data=0x3A097A, rsp_valid 2 cycles after pcpi_valid rises.
REQ-022 No responder, TIMEOUT_CYCLES=16 -> rsp_err=1 exactly 16 cycles after pcpi_valid rises; pcpi_valid low next cycle.
REQ-023 pcpi_wait held 40 cycles, then pcpi_ready -> no timeout, rsp_err=0; pcpi_ready coincident with timeout -> rsp_err=0.
REQ-024 rsp_ready held low 10 cycles -> rsp_data stable, cmd_ready=0 throughout.
REQ-025 resetn pulsed low during BUSY -> pcpi_valid=0 immediately, no rsp_valid, cmd_ready=1 after release; with filter enabled, insn 0x00000013 -> rsp_err=1, pcpi_valid never asserts.

Source files
------------

// File: rtl/pcpi_gf_initiator_pkg.sv
// rtl/pcpi_gf_initiator_pkg.sv - shared states, opcode constants and insn decode helper
package pcpi_gf_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [6:0] OPCODE_R = 7'b0110011;
  localparam logic [6:0] FUNCT7_R = 7'b0000001;
  localparam logic [6:0] FUNCT7_G = 7'b0000100;

  localparam logic [2:0] F3_CLMUL   = 3'd0;
  localparam logic [2:0] F3_CLMULH  = 3'd2;
  localparam logic [2:0] F3_GLWIDTH = 3'd4;
  localparam logic [2:0] F3_GFRED   = 3'd1;

  // True for R-type instructions in the M or GF extension space.
  function automatic logic insn_supported(input logic [31:0] insn);
    return (insn[6:0] == OPCODE_R) &&
           ((insn[31:25] == FUNCT7_R) || (insn[31:25] == FUNCT7_G));
  endfunction

endpackage

// File: rtl/pcpi_timeout_ctr.sv
// rtl/pcpi_timeout_ctr.sv - loadable down-counter flagging the decrement that reaches zero
module pcpi_timeout_ctr #(
  parameter int unsigned LOAD_VAL = 16
) (
  input  logic clk,
  input  logic resetn,
  input  logic load_i,
  input  logic dec_i,
  output logic zero_o
);

  localparam int unsigned CW = $clog2(LOAD_VAL + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Load wins over decrement; the count never wraps below zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(LOAD_VAL);
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the cycle whose decrement brings the count to zero, so the owner
  // can leave on that same edge rather than one cycle later.
  assign zero_o = dec_i && !load_i && (cnt_q == CW'(1));

endmodule

// File: rtl/pcpi_gf_initiator.sv
// rtl/pcpi_gf_initiator.sv - command/response front end issuing PCPI requests (optional PCPI_GF_INITIATOR_INSN_FILTER_EN)
module pcpi_gf_initiator
  import pcpi_gf_initiator_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [31:0]           cmd_insn,
  input  logic [DATA_WIDTH-1:0] cmd_rs1,
  input  logic [DATA_WIDTH-1:0] cmd_rs2,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_wr,
  output logic                  rsp_err,
  output logic                  pcpi_valid,
  output logic [31:0]           pcpi_insn,
  output logic [DATA_WIDTH-1:0] pcpi_rs1,
  output logic [DATA_WIDTH-1:0] pcpi_rs2,
  input  logic                  pcpi_wr,
  input  logic [DATA_WIDTH-1:0] pcpi_rd,
  input  logic                  pcpi_wait,
  input  logic                  pcpi_ready
);

  state_e                state_q, state_d;
  logic [31:0]           insn_q, insn_d;
  logic [DATA_WIDTH-1:0] rs1_q, rs1_d;
  logic [DATA_WIDTH-1:0] rs2_q, rs2_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  rsp_wr_q, rsp_wr_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  live_q;

  logic accept;
  logic busy;
  logic ctr_load;
  logic ctr_dec;
  logic expired;

  // cmd_ready depends only on registered state, never on cmd_valid.
  assign cmd_ready = live_q && (state_q == ST_IDLE);
  assign accept    = cmd_ready && cmd_valid;
  assign busy      = (state_q == ST_BUSY);

  // Any pcpi_wait cycle means the responder has claimed the insn, so restart.
  assign ctr_load = accept || (busy && pcpi_wait);
  assign ctr_dec  = busy && !pcpi_wait && !pcpi_ready;

  pcpi_timeout_ctr #(
    .LOAD_VAL (TIMEOUT_CYCLES)
  ) u_timeout_ctr (
    .clk    (clk),
    .resetn (resetn),
    .load_i (ctr_load),
    .dec_i  (ctr_dec),
    .zero_o (expired)
  );

  // Next-state and response capture; pcpi_ready outranks the timeout.
  always_comb begin
    state_d    = state_q;
    insn_d     = insn_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rsp_data_d = rsp_data_q;
    rsp_wr_d   = rsp_wr_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          insn_d = cmd_insn;
          rs1_d  = cmd_rs1;
          rs2_d  = cmd_rs2;
`ifdef PCPI_GF_INITIATOR_INSN_FILTER_EN
          if (!insn_supported(cmd_insn)) begin
            state_d    = ST_RESP;
            rsp_data_d = '0;
            rsp_wr_d   = 1'b0;
            rsp_err_d  = 1'b1;
          end else begin
            state_d = ST_BUSY;
          end
`else
          state_d = ST_BUSY;
`endif
        end
      end
      ST_BUSY: begin
        if (pcpi_ready) begin
          state_d    = ST_RESP;
          rsp_data_d = pcpi_wr ? pcpi_rd : '0;
          rsp_wr_d   = pcpi_wr;
          rsp_err_d  = 1'b0;
        end else if (expired) begin
          state_d    = ST_RESP;
          rsp_data_d = '0;
          rsp_wr_d   = 1'b0;
          rsp_err_d  = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any in-flight command.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      insn_q     <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rsp_data_q <= '0;
      rsp_wr_q   <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      insn_q     <= insn_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rsp_data_q <= rsp_data_d;
      rsp_wr_q   <= rsp_wr_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  // Holds cmd_ready low until the first clock edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      live_q <= 1'b0;
    end else begin
      live_q <= 1'b1;
    end
  end

  assign pcpi_valid = busy;
  assign pcpi_insn  = insn_q;
  assign pcpi_rs1   = rs1_q;
  assign pcpi_rs2   = rs2_q;
  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_data   = rsp_data_q;
  assign rsp_wr     = rsp_wr_q;
  assign rsp_err    = rsp_err_q;

endmodule
